// File: rtl/dpram_pkg.sv
// Shared constants, sequencer state type and lane-merge helper for dpram_be.
// Widths are capped at MAX_DATA_W / MAX_LANES so one function serves every instance.
package dpram_pkg;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  localparam int MAX_DATA_W = 256;
  localparam int MAX_LANES  = 256;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } seq_state_t;

  typedef logic [MAX_DATA_W-1:0] wide_word_t;
  typedef logic [MAX_LANES-1:0]  wide_be_t;

  // Lane i of the result comes from new_word when be[i] is set, else from old_word.
  function automatic wide_word_t merge_lanes(input wide_word_t old_word,
                                             input wide_word_t new_word,
                                             input wide_be_t   be,
                                             input int         byte_width);
    wide_word_t res;
    res = old_word;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (be[i / byte_width]) res[i] = new_word[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Post-reset memory clear sequencer: sweeps every address once, holding busy
// high until the final write has been issued.
module dpram_clear_seq
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_we
);

  seq_state_t            state;
  logic [ADDR_WIDTH-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt   <= '0;
      busy  <= (CLEAR_ON_RESET != 0);
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

  // The sweep write stalls while reset is held so a restart always begins at 0.
  assign clr_addr = cnt;
  assign clr_we   = (state == CLEAR) && !reset;

endmodule

// File: rtl/dpram_be.sv
// Single-clock true dual-port RAM with byte enables, deterministic collision
// handling, selectable read-during-write, optional output register and clear sweep.
module dpram_be
  import dpram_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 10,
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    BYTE_WIDTH     = 8,
  parameter int                    RDW_MODE       = 0,
  parameter int                    OUT_REG        = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  localparam int                   LANES          = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  busy,

  input  logic                  rden_a,
  input  logic                  wren_a,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [LANES-1:0]      byteena_a,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic                  q_valid_a,

  input  logic                  rden_b,
  input  logic                  wren_b,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [LANES-1:0]      byteena_b,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  q_valid_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  if ((BYTE_WIDTH < 1) || (DATA_WIDTH % BYTE_WIDTH != 0) ||
      (DATA_WIDTH > MAX_DATA_W) || (LANES > MAX_LANES)) begin : g_bad_params
    $error("dpram_be: DATA_WIDTH must be a non-zero multiple of BYTE_WIDTH within MAX_DATA_W");
  end

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_word,
                                                  input logic [DATA_WIDTH-1:0] new_word,
                                                  input logic [LANES-1:0]      be);
    wide_word_t o, n, r;
    wide_be_t   e;
    o = '0;
    n = '0;
    e = '0;
    o[DATA_WIDTH-1:0] = old_word;
    n[DATA_WIDTH-1:0] = new_word;
    e[LANES-1:0]      = be;
    r = merge_lanes(o, n, e, BYTE_WIDTH);
    return r[DATA_WIDTH-1:0];
  endfunction

  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_we;

  dpram_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clock    (clock),
    .reset    (reset),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  act_a, act_b, we_a, we_b, same_addr;
  logic [DATA_WIDTH-1:0] old_a, old_b, final_a, final_b, rd_a, rd_b;

  assign act_a     = (rden_a || wren_a) && !busy && !reset;
  assign act_b     = (rden_b || wren_b) && !busy && !reset;
  assign we_a      = act_a && wren_a && (|byteena_a);
  assign we_b      = act_b && wren_b && (|byteena_b);
  assign same_addr = (address_a == address_b);
  assign old_a     = mem[address_a];
  assign old_b     = mem[address_b];

  // B merges first and A last, so A wins every lane both ports enable.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    final_a = old_a;
    if (we_b && same_addr) final_a = merge(final_a, data_b, byteena_b);
    if (we_a)              final_a = merge(final_a, data_a, byteena_a);
    final_b = old_b;
    if (we_b)              final_b = merge(final_b, data_b, byteena_b);
    if (we_a && same_addr) final_b = merge(final_b, data_a, byteena_a);
  end

  // A non-writing port always sees the pre-write word, even on a collision.
  assign rd_a = (we_a && RDW_MODE == RDW_WRITE_FIRST) ? final_a : old_a;
  assign rd_b = (we_b && RDW_MODE == RDW_WRITE_FIRST) ? final_b : old_b;

  logic                  wa_en;
  logic [ADDR_WIDTH-1:0] wa_addr;
  logic [DATA_WIDTH-1:0] wa_data;

  assign wa_en   = clr_we || we_a;
  assign wa_addr = clr_we ? clr_addr : address_a;
  assign wa_data = clr_we ? CLEAR_VALUE : final_a;

  // NOTE: the array has no reset branch; contents are only initialised by the
  // clear sweep, which keeps the storage mappable onto block RAM.
  always_ff @(posedge clock) begin
    if (we_b)  mem[address_b] <= final_b;
    if (wa_en) mem[wa_addr]   <= wa_data;
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] s1_data_a, s1_data_b;
    logic                  s1_valid_a, s1_valid_b;

    always_ff @(posedge clock) begin
      if (reset) begin
        s1_data_a  <= '0;
        s1_data_b  <= '0;
        s1_valid_a <= 1'b0;
        s1_valid_b <= 1'b0;
        q_a        <= '0;
        q_b        <= '0;
        q_valid_a  <= 1'b0;
        q_valid_b  <= 1'b0;
      end else begin
        s1_valid_a <= act_a;
        s1_valid_b <= act_b;
        if (act_a)      s1_data_a <= rd_a;
        if (act_b)      s1_data_b <= rd_b;
        q_valid_a <= s1_valid_a;
        q_valid_b <= s1_valid_b;
        if (s1_valid_a) q_a <= s1_data_a;
        if (s1_valid_b) q_b <= s1_data_b;
      end
    end
  end else begin : g_no_out_reg
    always_ff @(posedge clock) begin
      if (reset) begin
        q_a       <= '0;
        q_b       <= '0;
        q_valid_a <= 1'b0;
        q_valid_b <= 1'b0;
      end else begin
        q_valid_a <= act_a;
        q_valid_b <= act_b;
        if (act_a) q_a <= rd_a;
        if (act_b) q_b <= rd_b;
      end
    end
  end

endmodule
